arbitro_barramento: RTL and testbench

//  Sequences the shared 16-bit tri-state Data bus of the processor datapath between NUM_REQ units (temp, ACC, RAM port, ...).

---
 rtl/arbitro_barramento.sv | 185 ++++++++++++++++++
 tb/tb_arbitro_barramento.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_barramento.sv
// arbitro_barramento
//   Sequences the shared 16-bit tri-state Data bus between NUM_REQ units.
//   It grants one requester at a time and drives that unit's bus-driver enable.
//   It then strobes the load of the addressed destination unit.
//   A turnaround cycle separates transfers, so two drivers never overlap on Data.
//   This block is pure control and never touches bus data.
//
// Parameters
//   NUM_REQ  number of bus units / requesters (2..8)
//   IDW      width of a unit id, equal to $clog2(NUM_REQ)
//
// Ports
//   clock   in   rising-edge clock
//   resetn  in   asynchronous active-low reset
//   req     in   req[i]=1: unit i asks to drive Data toward dst_i
//   dst     in   dst_i = dst[i*IDW +: IDW], destination id for unit i
//   gnt     out  one-hot grant, held DRIVE..TURN
//   drv_en  out  one-hot bus-driver enable
//   ld_en   out  one-hot load strobe (destination captures at next edge)
//   done    out  1-cycle pulse to the granted unit at transfer end
//   err     out  1-cycle pulse with done for an illegal request
//   busy    out  high in any state other than IDLE
//
// Build option
//   ARB_RR_EN  defined: round-robin arbitration, search starts at ptr+1.
//              undefined: fixed priority, lowest eligible index wins.

module arbitro_barramento #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = 2
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*IDW-1:0] dst,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     drv_en,
  output logic [NUM_REQ-1:0]     ld_en,
  output logic [NUM_REQ-1:0]     done,
  output logic                   err,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, DRIVE, CAPT, TURN} state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     s_q, s_d, d_q, d_d;
  logic               ill_q, ill_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, drv_q, drv_d, ld_q, ld_d, done_q, done_d;
  logic               err_q, err_d, busy_q, busy_d;

  logic [IDW-1:0]     dst_a [NUM_REQ];
  logic [NUM_REQ-1:0] elig;
  logic               win_vld;
  logic [IDW-1:0]     win_idx, cand;
`ifdef ARB_RR_EN
  logic [IDW-1:0]     ptr_q, ptr_d;
`endif

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      dst_a[i] = dst[i*IDW +: IDW];
    end
  end

  // The unit that just finished is masked in TURN so a held req cannot win twice in a row.
  always_comb begin
    elig = req;
    if (state_q == TURN) elig[s_q] = 1'b0;
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
`ifdef ARB_RR_EN
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((32'(ptr_q) + k) % NUM_REQ);
      if (!win_vld && elig[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
`else
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDW'(i);
      if (!win_vld && elig[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
`endif
  end

  // Outputs are decoded from the next state and registered.
  // The pins therefore follow the state register with no req->out path.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    d_d     = d_q;
    ill_d   = ill_q;
    case (state_q)
      IDLE, TURN: begin
        if (win_vld) begin
          state_d = DRIVE;
          s_d     = win_idx;
          d_d     = dst_a[win_idx];
          ill_d   = (dst_a[win_idx] == win_idx) || (32'(dst_a[win_idx]) >= NUM_REQ);
        end else begin
          state_d = IDLE;
        end
      end
      DRIVE:   state_d = CAPT;
      CAPT:    state_d = TURN;
      default: state_d = IDLE;
    endcase

    gnt_d  = '0;
    drv_d  = '0;
    ld_d   = '0;
    done_d = '0;
    err_d  = 1'b0;
    busy_d = (state_d != IDLE);
    case (state_d)
      DRIVE: begin
        gnt_d[s_d] = 1'b1;
        drv_d[s_d] = !ill_d;
      end
      CAPT: begin
        gnt_d[s_d] = 1'b1;
        drv_d[s_d] = !ill_d;
        if (!ill_d) ld_d[d_d] = 1'b1;
      end
      TURN: begin
        gnt_d[s_d]  = 1'b1;
        done_d[s_d] = 1'b1;
        err_d       = ill_d;
      end
      default: ;
    endcase
  end

`ifdef ARB_RR_EN
  always_comb begin
    ptr_d = (state_q == CAPT) ? s_q : ptr_q;
  end
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      s_q     <= '0;
      d_q     <= '0;
      ill_q   <= 1'b0;
      gnt_q   <= '0;
      drv_q   <= '0;
      ld_q    <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef ARB_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      d_q     <= d_d;
      ill_q   <= ill_d;
      gnt_q   <= gnt_d;
      drv_q   <= drv_d;
      ld_q    <= ld_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
`ifdef ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign gnt    = gnt_q;
  assign drv_en = drv_q;
  assign ld_en  = ld_q;
  assign done   = done_q;
  assign err    = err_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_arbitro_barramento.sv
// tb_arbitro_barramento
//   Bench for arbitro_barramento.
//   u_dut  has NUM_REQ=4 and IDW=2.
//   u_dut3 has NUM_REQ=3 and IDW=2, used for the out-of-range destination case.
//   A monitor gathers one record per finished transfer.
//   Each scenario task queues the records it expects and compares them in order.

module tb_arbitro_barramento;

  logic       clock  = 1'b0;
  logic       resetn = 1'b1;
  logic [3:0] req, gnt, drv_en, ld_en, done;
  logic [7:0] dst;
  logic       err, busy;
  logic [2:0] req3, gnt3, drv3, ld3, done3;
  logic [5:0] dst3;
  logic       err3, busy3;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int rd     = 0;

  typedef struct packed {
    logic [3:0] done;
    logic       err;
    logic [3:0] ld;
    logic [3:0] drv;
    logic [3:0] ncyc;
  } rec_t;

  rec_t       exp_q[$];
  rec_t       obs_q[$];
  int         t_q[$];
  logic [3:0] a_ld  = '0;
  logic [3:0] a_drv = '0;
  logic [3:0] a_cyc = '0;

  arbitro_barramento #(.NUM_REQ(4), .IDW(2)) u_dut (
    .clock(clock), .resetn(resetn), .req(req), .dst(dst), .gnt(gnt),
    .drv_en(drv_en), .ld_en(ld_en), .done(done), .err(err), .busy(busy)
  );

  arbitro_barramento #(.NUM_REQ(3), .IDW(2)) u_dut3 (
    .clock(clock), .resetn(resetn), .req(req3), .dst(dst3), .gnt(gnt3),
    .drv_en(drv3), .ld_en(ld3), .done(done3), .err(err3), .busy(busy3)
  );

  always #5 clock = ~clock;

  // Transfer recorder plus the one-hot invariants.
  always @(negedge clock) begin
    cyc++;
    if (!resetn) begin
      a_ld  <= '0;
      a_drv <= '0;
      a_cyc <= '0;
    end else begin
      assert ($onehot0(gnt) && $onehot0(drv_en) && $onehot0(ld_en) && !(err && done == 4'b0))
        else $error("FAIL onehot gnt=%b drv_en=%b ld_en=%b err=%b done=%b", gnt, drv_en, ld_en, err, done);
      assert ($onehot0(gnt3) && $onehot0(drv3) && $onehot0(ld3))
        else $error("FAIL onehot3 gnt=%b drv_en=%b ld_en=%b", gnt3, drv3, ld3);
      if (done != 4'b0) begin
        obs_q.push_back('{done, err, a_ld | ld_en, a_drv | drv_en, a_cyc + ((drv_en != 4'b0) ? 4'd1 : 4'd0)});
        t_q.push_back(cyc);
        a_ld  <= '0;
        a_drv <= '0;
        a_cyc <= '0;
      end else begin
        a_ld  <= a_ld | ld_en;
        a_drv <= a_drv | drv_en;
        if (drv_en != 4'b0) a_cyc <= a_cyc + 4'd1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
      #1;
    end
  endtask

  task automatic wait_obs(input int n, input int limit);
    for (int c = 0; c < limit && (obs_q.size() - rd) < n; c++) step(1);
  endtask

  task automatic test_reset;
    req = '0; dst = '0; req3 = '0; dst3 = '0;
    resetn = 1'b0;
    step(1);
    total++;
    if ({gnt, drv_en, ld_en, done, err, busy} !== 18'b0)
      $display("FAIL reset_hold gnt=%b drv=%b ld=%b done=%b err=%b busy=%b, expected all 0", gnt, drv_en, ld_en, done, err, busy);
    else passed++;
    step(1);
    resetn = 1'b1;
    step(2);
    total++;
    if ({gnt, busy, gnt3, busy3} !== 8'b0)
      $display("FAIL reset_idle gnt=%b busy=%b gnt3=%b busy3=%b, expected 0", gnt, busy, gnt3, busy3);
    else passed++;
  endtask

  task automatic test_single;
    rec_t e, o;
    req = 4'b0001; dst = 8'b00_00_00_10;
    exp_q.push_back('{4'b0001, 1'b0, 4'b0100, 4'b0001, 4'd2});
    step(1);
    req = '0;
    total++;
    if ({gnt, drv_en, ld_en, busy} !== {4'b0001, 4'b0001, 4'b0000, 1'b1})
      $display("FAIL single_c1 gnt=%b drv=%b ld=%b busy=%b, expected 0001 0001 0000 1", gnt, drv_en, ld_en, busy);
    else passed++;
    step(1);
    total++;
    if ({drv_en, ld_en} !== {4'b0001, 4'b0100})
      $display("FAIL single_c2 drv=%b ld=%b, expected 0001 0100", drv_en, ld_en);
    else passed++;
    step(1);
    total++;
    if ({gnt, drv_en, ld_en, done, err} !== {4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0})
      $display("FAIL single_c3 gnt=%b drv=%b ld=%b done=%b err=%b, expected 0001 0000 0000 0001 0", gnt, drv_en, ld_en, done, err);
    else passed++;
    step(1);
    total++;
    if ({busy, gnt, done} !== 9'b0)
      $display("FAIL single_c4 busy=%b gnt=%b done=%b, expected idle", busy, gnt, done);
    else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (rd >= obs_q.size()) $display("FAIL sb_single missing transfer, expected done=%b", e.done);
      else begin
        o = obs_q[rd]; rd++;
        if (o !== e) $display("FAIL sb_single got done=%b err=%b ld=%b drv=%b ncyc=%0d, expected done=%b err=%b ld=%b drv=%b ncyc=%0d",
                              o.done, o.err, o.ld, o.drv, o.ncyc, e.done, e.err, e.ld, e.drv, e.ncyc);
        else passed++;
      end
    end
  endtask

  task automatic test_back_to_back;
    rec_t e, o;
    int   ord[6];
    int   rd0, s, d;
`ifdef ARB_RR_EN
    ord = '{1, 2, 3, 0, 1, 2};
`else
    ord = '{0, 1, 0, 1, 0, 1};
`endif
    // Each unit i targets (i+1) mod 4.
    dst = {2'd0, 2'd3, 2'd2, 2'd1};
    for (int k = 0; k < 6; k++) begin
      s = ord[k];
      d = (s + 1) % 4;
      exp_q.push_back('{4'(1 << s), 1'b0, 4'(1 << d), 4'(1 << s), 4'd2});
    end
    rd0 = rd;
    req = 4'b1111;
    wait_obs(6, 40);
    req = '0;
    step(2);
    total++;
    if (busy !== 1'b0) $display("FAIL b2b_idle busy=%b, expected 0", busy);
    else passed++;
    for (int j = 1; j < 6; j++) begin
      total++;
      if (rd0 + j >= t_q.size()) $display("FAIL b2b_gap%0d missing done, expected spacing 3", j);
      else if (t_q[rd0 + j] - t_q[rd0 + j - 1] != 3)
        $display("FAIL b2b_gap%0d spacing=%0d, expected 3", j, t_q[rd0 + j] - t_q[rd0 + j - 1]);
      else passed++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (rd >= obs_q.size()) $display("FAIL sb_b2b missing transfer, expected done=%b", e.done);
      else begin
        o = obs_q[rd]; rd++;
        if (o !== e) $display("FAIL sb_b2b got done=%b err=%b ld=%b drv=%b ncyc=%0d, expected done=%b err=%b ld=%b drv=%b ncyc=%0d",
                              o.done, o.err, o.ld, o.drv, o.ncyc, e.done, e.err, e.ld, e.drv, e.ncyc);
        else passed++;
      end
    end
  endtask

  task automatic test_illegal;
    rec_t e, o;
    // Unit 1 targets itself (illegal); unit 2 targets unit 0.
    dst = 8'b00_00_01_00;
    exp_q.push_back('{4'b0010, 1'b1, 4'b0000, 4'b0000, 4'd0});
    exp_q.push_back('{4'b0100, 1'b0, 4'b0001, 4'b0100, 4'd2});
    req = 4'b0110;
    wait_obs(2, 20);
    req = '0;
    step(2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (rd >= obs_q.size()) $display("FAIL sb_illegal missing transfer, expected done=%b", e.done);
      else begin
        o = obs_q[rd]; rd++;
        if (o !== e) $display("FAIL sb_illegal got done=%b err=%b ld=%b drv=%b ncyc=%0d, expected done=%b err=%b ld=%b drv=%b ncyc=%0d",
                              o.done, o.err, o.ld, o.drv, o.ncyc, e.done, e.err, e.ld, e.drv, e.ncyc);
        else passed++;
      end
    end
  endtask

  task automatic test_latched_dst;
    rec_t e, o;
    dst = 8'b00_11_00_00;
    req = 4'b0100;
    exp_q.push_back('{4'b0100, 1'b0, 4'b1000, 4'b0100, 4'd2});
    step(1);
    total++;
    if (gnt !== 4'b0100) $display("FAIL latch_gnt gnt=%b, expected 0100", gnt);
    else passed++;
    // Dropping req and changing dst mid-transfer must not affect this transfer.
    req = '0; dst = '0;
    wait_obs(1, 10);
    step(1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (rd >= obs_q.size()) $display("FAIL sb_latch missing transfer, expected done=%b", e.done);
      else begin
        o = obs_q[rd]; rd++;
        if (o !== e) $display("FAIL sb_latch got done=%b err=%b ld=%b drv=%b ncyc=%0d, expected done=%b err=%b ld=%b drv=%b ncyc=%0d",
                              o.done, o.err, o.ld, o.drv, o.ncyc, e.done, e.err, e.ld, e.drv, e.ncyc);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid;
    rec_t e, o;
    dst = 8'b00_00_00_11;
    req = 4'b0001;
    step(1);
    req = '0;
    step(1);
    total++;
    if (ld_en !== 4'b1000) $display("FAIL rmid_capt ld=%b, expected 1000", ld_en);
    else passed++;
    #2 resetn = 1'b0;
    #1;
    total++;
    if ({gnt, drv_en, ld_en, busy} !== 13'b0)
      $display("FAIL rmid_async gnt=%b drv=%b ld=%b busy=%b, expected 0", gnt, drv_en, ld_en, busy);
    else passed++;
    step(2);
    resetn = 1'b1;
    step(2);
    total++;
    if (obs_q.size() != rd || done !== 4'b0)
      $display("FAIL rmid_nodone records=%0d done=%b, expected 0 new and 0000", obs_q.size() - rd, done);
    else passed++;
    // The pointer restarts at 0 after reset.
    dst = 8'b10_00_00_01;
    req = 4'b1001;
`ifdef ARB_RR_EN
    exp_q.push_back('{4'b1000, 1'b0, 4'b0100, 4'b1000, 4'd2});
`else
    exp_q.push_back('{4'b0001, 1'b0, 4'b0010, 4'b0001, 4'd2});
`endif
    step(1);
    req = '0;
    wait_obs(1, 10);
    step(1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (rd >= obs_q.size()) $display("FAIL sb_rmid missing transfer, expected done=%b", e.done);
      else begin
        o = obs_q[rd]; rd++;
        if (o !== e) $display("FAIL sb_rmid got done=%b err=%b ld=%b drv=%b ncyc=%0d, expected done=%b err=%b ld=%b drv=%b ncyc=%0d",
                              o.done, o.err, o.ld, o.drv, o.ncyc, e.done, e.err, e.ld, e.drv, e.ncyc);
        else passed++;
      end
    end
  endtask

  task automatic test_out_of_range;
    logic saw_ld = 1'b0;
    dst3 = 6'b00_00_11;
    req3 = 3'b001;
    step(1);
    req3 = '0;
    total++;
    if ({gnt3, drv3} !== {3'b001, 3'b000})
      $display("FAIL oor_drive gnt=%b drv=%b, expected 001 000", gnt3, drv3);
    else passed++;
    saw_ld = (ld3 != 3'b0);
    step(1);
    saw_ld = saw_ld | (ld3 != 3'b0);
    total++;
    if (drv3 !== 3'b000) $display("FAIL oor_capt drv=%b, expected 000", drv3);
    else passed++;
    step(1);
    total++;
    if ({done3, err3} !== {3'b001, 1'b1})
      $display("FAIL oor_turn done=%b err=%b, expected 001 1", done3, err3);
    else passed++;
    saw_ld = saw_ld | (ld3 != 3'b0);
    total++;
    if (saw_ld !== 1'b0) $display("FAIL oor_noload ld seen=%b, expected 0", saw_ld);
    else passed++;
    step(1);
    total++;
    if ({busy3, err3} !== 2'b00) $display("FAIL oor_idle busy=%b err=%b, expected 0 0", busy3, err3);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_illegal();
    test_latched_dst();
    test_reset_mid();
    test_out_of_range();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
